// File: rtl/cpu_trace_checker.sv
// -----------------------------------------------------------------------------
// cpu_trace_checker
//
// Streams a CPU trace one ASCII character per clock and recognises two line
// formats:
//   register line:  ^T@P: $G <=D#
//   memory line:    ^T@P: *A <=D#
// T is 1..TIME_DIGITS decimal digits, G is 1..GRF_DIGITS decimal digits, and
// P, A, D are exactly 8 lowercase hex digits. When a well-formed line ends,
// the FSM spends exactly one cycle in DONE. During that cycle format_type
// reports the line kind and error_code reports semantic problems with the
// parsed fields.
//
// Ports:
//   clk         - single clock, rising edge.
//   reset       - asynchronous, active-low reset.
//   char        - ASCII character consumed on each rising edge.
//   format_type - 00 none, 01 register line, 10 memory line (DONE only).
//   error_code  - {grf>31, bad addr, bad PC, odd time} (DONE only).
//   line_count  - saturating count of well-formed lines completed.
// -----------------------------------------------------------------------------
module cpu_trace_checker #(
    parameter int          TIME_DIGITS = 4,
    parameter int          GRF_DIGITS  = 4,
    parameter logic [31:0] PC_MIN      = 32'h0000_3000,
    parameter logic [31:0] PC_MAX      = 32'h0000_6FFF,
    parameter logic [31:0] ADDR_MAX    = 32'h0000_2FFF,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic [CNT_W-1:0] line_count
);

    typedef enum logic [3:0] {
        IDLE, HAT, TIME, PC, COLSP, GRF0, GRF, ADDR0, ADDR,
        PRESP, LT, EQSP, DATA, DONE
    } state_t;

    localparam logic [7:0] TIME_LIM = 8'(TIME_DIGITS);
    localparam logic [7:0] GRF_LIM  = 8'(GRF_DIGITS);
    localparam logic [7:0] HEX_LEN  = 8'd8;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              time_odd_q, time_odd_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       addr_q, addr_d;
    logic [13:0]       grf_q, grf_d;
    logic              is_mem_q, is_mem_d;
    logic [3:0]        err_q, err_d;
    logic [CNT_W-1:0]  line_count_q, line_count_d;

    logic              is_dig;
    logic              is_hex;
    logic [3:0]        nib;

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        logic [7:0] t;
        if (c <= 8'h39) t = c - 8'h30;
        else            t = c - 8'h57;
        return t[3:0];
    endfunction

    // Decimal accumulate with saturation at the 14-bit maximum.
    function automatic logic [13:0] grf_next(input logic [13:0] v,
                                             input logic [3:0]  d);
        logic [17:0] t;
        t = ({4'b0, v} * 18'd10) + {14'b0, d};
        return (t > 18'd16383) ? 14'h3FFF : t[13:0];
    endfunction

    assign is_dig = (char >= 8'h30) && (char <= 8'h39);
    assign is_hex = is_dig || ((char >= 8'h61) && (char <= 8'h66));
    assign nib    = hex_val(char);

    always_comb begin
        state_d      = IDLE;
        cnt_d        = cnt_q;
        time_odd_d   = time_odd_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        grf_d        = grf_q;
        is_mem_d     = is_mem_q;
        err_d        = err_q;
        line_count_d = line_count_q;

        case (state_q)
            IDLE: state_d = IDLE;
            HAT: begin
                if (is_dig) begin
                    state_d    = TIME;
                    time_odd_d = char[0];
                    cnt_d      = 8'd1;
                end
            end
            TIME: begin
                if (is_dig && cnt_q < TIME_LIM) begin
                    state_d    = TIME;
                    time_odd_d = char[0];
                    cnt_d      = cnt_q + 8'd1;
                end else if (char == "@") begin
                    state_d = PC;
                    cnt_d   = 8'd0;
                end
            end
            PC: begin
                if (is_hex && cnt_q < HEX_LEN) begin
                    state_d = PC;
                    pc_d    = {pc_q[27:0], nib};
                    cnt_d   = cnt_q + 8'd1;
                end else if (char == ":" && cnt_q == HEX_LEN) begin
                    state_d = COLSP;
                end
            end
            COLSP: begin
                if (char == " ") begin
                    state_d = COLSP;
                end else if (char == "$") begin
                    state_d  = GRF0;
                    is_mem_d = 1'b0;
                end else if (char == "*") begin
                    state_d  = ADDR0;
                    is_mem_d = 1'b1;
                end
            end
            GRF0: begin
                if (is_dig) begin
                    state_d = GRF;
                    grf_d   = {10'b0, nib};
                    cnt_d   = 8'd1;
                end
            end
            GRF: begin
                if (is_dig && cnt_q < GRF_LIM) begin
                    state_d = GRF;
                    grf_d   = grf_next(grf_q, nib);
                    cnt_d   = cnt_q + 8'd1;
                end else if (char == " ") begin
                    state_d = PRESP;
                end else if (char == "<") begin
                    state_d = LT;
                end
            end
            ADDR0: begin
                if (is_hex) begin
                    state_d = ADDR;
                    addr_d  = {28'b0, nib};
                    cnt_d   = 8'd1;
                end
            end
            ADDR: begin
                if (is_hex && cnt_q < HEX_LEN) begin
                    state_d = ADDR;
                    addr_d  = {addr_q[27:0], nib};
                    cnt_d   = cnt_q + 8'd1;
                end else if (char == " " && cnt_q == HEX_LEN) begin
                    state_d = PRESP;
                end else if (char == "<" && cnt_q == HEX_LEN) begin
                    state_d = LT;
                end
            end
            PRESP: begin
                if (char == " ")      state_d = PRESP;
                else if (char == "<") state_d = LT;
            end
            LT: begin
                if (char == "=") state_d = EQSP;
            end
            EQSP: begin
                if (char == " ") begin
                    state_d = EQSP;
                end else if (is_hex) begin
                    state_d = DATA;
                    cnt_d   = 8'd1;
                end
            end
            DATA: begin
                if (is_hex && cnt_q < HEX_LEN) begin
                    state_d = DATA;
                    cnt_d   = cnt_q + 8'd1;
                end else if (char == "#" && cnt_q == HEX_LEN) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A caret always restarts a line, whatever state we were in.
        if (char == "^") begin
            state_d = HAT;
        end

        // Entering HAT throws away everything gathered for the previous line.
        if (state_d == HAT) begin
            cnt_d      = 8'd0;
            time_odd_d = 1'b0;
            pc_d       = 32'd0;
            addr_d     = 32'd0;
            grf_d      = 14'd0;
            is_mem_d   = 1'b0;
        end

        // DONE can only be entered from DATA, so this fires once per line.
        if (state_d == DONE) begin
            err_d[0] = time_odd_q;
            err_d[1] = (pc_q < PC_MIN) || (pc_q > PC_MAX) || (pc_q[1:0] != 2'b00);
            err_d[2] = is_mem_q && ((addr_q > ADDR_MAX) || (addr_q[1:0] != 2'b00));
            err_d[3] = !is_mem_q && (grf_q > 14'd31);
            if (line_count_q != {CNT_W{1'b1}}) begin
                line_count_d = line_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            time_odd_q   <= 1'b0;
            pc_q         <= 32'd0;
            addr_q       <= 32'd0;
            grf_q        <= 14'd0;
            is_mem_q     <= 1'b0;
            err_q        <= 4'd0;
            line_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            time_odd_q   <= time_odd_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            grf_q        <= grf_d;
            is_mem_q     <= is_mem_d;
            err_q        <= err_d;
            line_count_q <= line_count_d;
        end
    end

    assign format_type = (state_q == DONE) ? (is_mem_q ? 2'b10 : 2'b01) : 2'b00;
    assign error_code  = (state_q == DONE) ? err_q : 4'b0000;
    assign line_count  = line_count_q;

endmodule

// File: tb/tb_cpu_trace_checker.sv
module tb_cpu_trace_checker;

    logic        clk;
    logic        reset;
    logic [7:0]  ch;
    logic [1:0]  format_type;
    logic [3:0]  error_code;
    logic [15:0] line_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [3:0]  err;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    cpu_trace_checker dut (
        .clk         (clk),
        .reset       (reset),
        .char        (ch),
        .format_type (format_type),
        .error_code  (error_code),
        .line_count  (line_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        ch = c;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic expect_line(input logic [1:0] f, input logic [3:0] e, input logic [15:0] c);
        exp_t x;
        x.fmt = f;
        x.err = e;
        x.cnt = c;
        exp_q.push_back(x);
    endtask

    // Monitor: every DONE cycle must match the next expected line record.
    always @(negedge clk) begin
        if (reset && format_type != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(format_type), 32'd0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("format_type", 32'(format_type), 32'(x.fmt));
                chk("error_code",  32'(error_code),  32'(x.err));
                chk("line_count",  32'(line_count),  32'(x.cnt));
            end
        end
    end

    // Watchdog: the stimulus is finite, so this only trips on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ch    = " ";
        reset = 1'b0;
        #12;
        chk("reset_fmt", 32'(format_type), 32'd0);
        chk("reset_err", 32'(error_code),  32'd0);
        chk("reset_cnt", 32'(line_count),  32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Clean register line, then a filler char: DONE lasts one cycle.
        expect_line(2'b01, 4'b0000, 16'd1);
        send_str("^10@00003000: $1 <= 0000000a#");
        send(" ");
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(format_type), 32'd0);

        // Memory line with odd time, low misaligned PC, out-of-range addr.
        expect_line(2'b10, 4'b0111, 16'd2);
        send_str("^11@00002ffe: *00003000 <=00000001#");

        // grf 32 is out of range; leading zeros in 0031 give 31.
        expect_line(2'b01, 4'b1000, 16'd3);
        send_str("^8@00003004: $32<=00000000#");
        expect_line(2'b01, 4'b0000, 16'd4);
        send_str("^8@00003004: $0031<=00000000#");

        // Malformed lines: no DONE, count unchanged.
        send_str("^12345@00003000: $1 <= 00000000#");
        send_str("^2@0000300: $1 <= 00000000#");
        send_str("^2@0000300A: $1 <= 00000000#");
        send(" ");
        @(posedge clk);
        #1;
        chk("malformed_cnt", 32'(line_count), 32'd4);
        chk("malformed_fmt", 32'(format_type), 32'd0);

        // Restart mid-line discards the partial line.
        expect_line(2'b01, 4'b0000, 16'd5);
        send_str("^4@000030^6@00003000: $2 <= 00000000#");

        // Reset between edges while in DATA.
        send_str("^2@00003000: $1 <= 0000");
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_fmt", 32'(format_type), 32'd0);
        chk("async_rst_err", 32'(error_code),  32'd0);
        chk("async_rst_cnt", 32'(line_count),  32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Leftover DATA chars of the killed line must not complete it.
        send_str("0000#");
        expect_line(2'b10, 4'b0000, 16'd1);
        send_str("^6@00003000: *00000ffc <= 12345678#");

        // PC above PC_MAX with odd time; grf 31 is still legal.
        expect_line(2'b01, 4'b0011, 16'd2);
        send_str("^3@00007000: $31 <= 00000000#");

        send(" ");
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("final_cnt", 32'(line_count), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
